// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding a start/data/stop serializer.
// tx is registered; queued bytes are sent back to back with no idle gap between frames.
module uart_tx_buffered #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  state_t        state_next;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_next;
  logic [7:0]    shift;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          bit_end;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          tx_d;

  assign bit_end    = (baud_cnt == BW'(DIV - 1));
  assign fifo_empty = (fifo_count == '0);
  // Full test looks at the registered count only: a pop in the same cycle never makes room.
  assign in_ready   = (fifo_count != CW'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign tx_busy    = (state != IDLE) || !fifo_empty;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first so every path drives state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && (bit_idx == 3'd7)) state_next = STOP;
      STOP:    if (bit_end) state_next = fifo_empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bit_idx_next = bit_idx;
    if (bit_end) begin
      if (state == START)     bit_idx_next = '0;
      else if (state == DATA) bit_idx_next = bit_idx + 3'd1;
    end
  end

  // tx is computed from the upcoming state so the registered line changes on the same edge.
  always_comb begin
    pop = (state_next == START) && ((state == IDLE) || (state == STOP));
    case (state_next)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift[bit_idx_next];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx         <= 1'b1;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      tx      <= tx_d;
      bit_idx <= bit_idx_next;
      if ((state == IDLE) || bit_end) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + BW'(1);
      if (pop) begin
        shift  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; pointers and count decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= in_data;
  end

endmodule
